// File: rtl/c_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : c_pipe_reg
//  Brief    : Elastic valid/ready pipeline register, DEPTH stages of WIDTH
//             bits, bubble-collapsing back-pressure and occupancy count.
//             Optional synchronous flush port enabled by C_PIPE_REG_FLUSH_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module c_pipe_reg #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         active,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef C_PIPE_REG_FLUSH_EN
  input  logic                         flush,
`endif
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_v;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_v_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_flush;
  logic             w_step;

`ifdef C_PIPE_REG_FLUSH_EN
  assign w_flush = active && flush;
`else
  assign w_flush = 1'b0;
`endif

  // Transfers only happen on active, non-flush edges.
  assign w_step = active && !w_flush;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             w_src_v;
      logic [WIDTH-1:0] w_src_d;
      logic [WIDTH-1:0] r_data;

      if (i == 0) begin : g_head
        assign w_src_v = in_valid;
        assign w_src_d = in_data;
      end else begin : g_body
        assign w_src_v = r_v[i-1];
        assign w_src_d = g_stage[i-1].r_data;
      end

      // Stage i can move unless it and every stage downstream of it is full
      // while the output is stalled; flattened form of the backward ready chain.
      assign w_rdy[i]    = out_ready || !(&r_v[DEPTH-1:i]);
      assign w_v_next[i] = w_rdy[i] ? w_src_v : r_v[i];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_data <= RESET_VALUE;
        end else if (w_step && w_rdy[i] && w_src_v) begin
          r_data <= w_src_d;
        end
      end
    end
  endgenerate

  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count_next = w_count_next + CNT_W'(w_v_next[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v     <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_v     <= '0;
      r_count <= '0;
    end else if (active) begin
      r_v     <= w_v_next;
      r_count <= w_count_next;
    end
  end

  assign in_ready  = w_step && w_rdy[0];
  assign out_valid = w_step && r_v[DEPTH-1];
  assign out_data  = g_stage[DEPTH-1].r_data;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_c_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c_pipe_reg
//  Brief    : Directed, table-driven self-checking bench for c_pipe_reg
//             (WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_c_pipe_reg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int NVEC  = 27;

  logic             clk;
  logic             reset;
  logic             active;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;
`ifdef C_PIPE_REG_FLUSH_EN
  logic             flush;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       vin;
    logic [7:0] din;
    logic       ordy;
    logic       act;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t tbl [NVEC];

  c_pipe_reg #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef C_PIPE_REG_FLUSH_EN
    .flush     (flush),
`endif
    .out_data  (out_data),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ir, input logic e_ov,
                         input logic [7:0] e_od, input logic [1:0] e_cnt);
    chk({tag, " in_ready"},  32'(in_ready),  32'(e_ir));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, " out_data"},  32'(out_data),  32'(e_od));
    chk({tag, " count"},     32'(count),     32'(e_cnt));
  endtask

  initial begin
    // vin, din, ordy, act | in_ready, out_valid, out_data, count (pre-edge)
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 2'd0};
    tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 2'd1};
    tbl[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 2'd2};
    tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 2'd3};
    tbl[4]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 2'd3};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 2'd3};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 2'd2};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 2'd1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 2'd0};
    tbl[9]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 2'd0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 2'd1};
    tbl[11] = '{1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 2'd1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 2'd2};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 2'd2};
    tbl[14] = '{1'b1, 8'hCC, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 2'd2};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 2'd3};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 2'd3};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 2'd3};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 2'd3};
    tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 2'd3};
    tbl[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hBB, 2'd2};
    tbl[21] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hCC, 2'd1};
    tbl[22] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'hCC, 2'd0};
    tbl[23] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 8'hCC, 2'd1};
    tbl[24] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 8'hCC, 2'd2};
    tbl[25] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd3};
    tbl[26] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 2'd3};

    reset     = 1'b0;
    active    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef C_PIPE_REG_FLUSH_EN
    flush     = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_all("reset", 1'b1, 1'b0, 8'hA5, 2'd0);
    @(negedge clk);
    reset = 1'b1;

    // Streaming 0x01..0x10 with out_ready high, then three idle drain cycles
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      in_valid  = (t < 16);
      in_data   = 8'(t + 1);
      out_ready = 1'b1;
      #1;
      chk($sformatf("stream%0d in_ready", t), 32'(in_ready), 32'd1);
      chk($sformatf("stream%0d out_valid", t), 32'(out_valid), 32'((t >= 3) && (t < 19)));
      if (t >= 3 && t < 19)
        chk($sformatf("stream%0d out_data", t), 32'(out_data), 32'(t - 2));
      chk($sformatf("stream%0d count", t), 32'(count),
          32'((t < 3) ? t : ((t <= 16) ? 3 : 19 - t)));
    end

    // Stall fill, drain, bubble collapse, active freeze, push+pop while full
    for (int k = 0; k < NVEC; k++) begin
      @(negedge clk);
      in_valid  = tbl[k].vin;
      in_data   = tbl[k].din;
      out_ready = tbl[k].ordy;
      active    = tbl[k].act;
      #1;
      chk_all($sformatf("vec%0d", k), tbl[k].e_ir, tbl[k].e_ov, tbl[k].e_od, tbl[k].e_cnt);
    end

    // Asynchronous reset while full: takes effect without a clock edge
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    active    = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 1'b1, 1'b0, 8'hA5, 2'd0);
    @(negedge clk);
    reset = 1'b1;

`ifdef C_PIPE_REG_FLUSH_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 8'(k + 1);
      out_ready = 1'b0;
    end
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h77;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    chk_all("flush_cycle", 1'b0, 1'b0, 8'h01, 2'd3);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1;
    chk_all("after_flush", 1'b1, 1'b0, 8'h01, 2'd0);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
